acc_bank: RTL and testbench

- Receive-side consumer of the systolic array's accumulator control.
- Captures per-column partial sums from the bottom PE row whenever the controller's per-column valid (acc_valid) is high.
- Removes the column skew and buffers one N x N result tile.
- Streams the tile out row by row over a valid/ready handshake toward the writeback/output path.

---
 rtl/acc_bank_pkg.sv | 33 +++
 rtl/acc_bank_if.sv | 38 +++
 rtl/acc_column.sv | 89 ++++++++
 rtl/acc_bank.sv | 147 ++++++++++++++
 tb/tb_acc_bank.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_bank_pkg.sv
// -----------------------------------------------------------------------------
// acc_bank_pkg
// Shared constants and types for the accumulator bank that sits below the
// systolic array: tile dimension, partial-sum width, FSM state encoding and
// small width helpers used to size pointers and row indices.
// No ports (package).
// -----------------------------------------------------------------------------
package acc_bank_pkg;

    localparam int N     = 4;   // array dimension: rows and columns per tile
    localparam int ACC_W = 32;  // signed partial-sum / result width

    // Bits needed to index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count 0..n (a write pointer may reach n).
    function automatic int ptr_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int LOG_N = idx_width(N);

    typedef logic signed [ACC_W-1:0] psum_t;

    typedef enum logic [1:0] {
        S_ACC_IDLE   = 2'd0,
        S_ACC_ACTIVE = 2'd1,
        S_ACC_DONE   = 2'd2
    } acc_state_t;

endpackage

// File: rtl/acc_bank_if.sv
// -----------------------------------------------------------------------------
// acc_bank_if
// Row-stream handshake between the accumulator bank (master) and the
// writeback/output path (slave).
//   row_o       : current output row, element c is column c
//   row_idx_o   : index of the row on row_o
//   row_valid_o : row_o holds a complete row
//   row_ready_i : downstream accepts the row this cycle
// Signal suffixes are named from the bank's point of view.
// -----------------------------------------------------------------------------
interface acc_bank_if #(
    parameter int N     = acc_bank_pkg::N,
    parameter int ACC_W = acc_bank_pkg::ACC_W
);
    import acc_bank_pkg::*;

    localparam int IW = idx_width(N);

    logic [N-1:0][ACC_W-1:0] row_o;
    logic [IW-1:0]           row_idx_o;
    logic                    row_valid_o;
    logic                    row_ready_i;

    modport master (
        output row_o,
        output row_idx_o,
        output row_valid_o,
        input  row_ready_i
    );

    modport slave (
        input  row_o,
        input  row_idx_o,
        input  row_valid_o,
        output row_ready_i
    );

endinterface

// File: rtl/acc_column.sv
// -----------------------------------------------------------------------------
// acc_column
// One column of the accumulator bank: N-entry storage filled in arrival order,
// its write pointer, a sticky overflow flag and the optional accumulate adder.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   clear_i        : new tile; zero the pointer and overflow flag
//   cap_en_i       : bank is accepting captures this cycle
//   valid_i        : capture strobe for this column
//   psum_i         : partial sum from the bottom PE of this column
//   accumulate_i   : 1 = add into storage, 0 = overwrite
//   rd_idx_i       : row to present on rd_data_o
//   wp_o           : number of entries captured so far (0..N)
//   rd_data_o      : storage entry at rd_idx_i
//   ovf_o          : a capture arrived while the column was full
// -----------------------------------------------------------------------------
module acc_column #(
    parameter  int N     = acc_bank_pkg::N,
    parameter  int ACC_W = acc_bank_pkg::ACC_W,
    localparam int IW    = acc_bank_pkg::idx_width(N),
    localparam int PW    = acc_bank_pkg::ptr_width(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             cap_en_i,
    input  logic             valid_i,
    input  logic [ACC_W-1:0] psum_i,
    input  logic             accumulate_i,
    input  logic [IW-1:0]    rd_idx_i,
    output logic [PW-1:0]    wp_o,
    output logic [ACC_W-1:0] rd_data_o,
    output logic             ovf_o
);
    import acc_bank_pkg::*;

    logic [N-1:0][ACC_W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wp_q,  wp_d;
    logic                    ovf_q, ovf_d;
    logic [IW-1:0]           wr_idx;

    // The pointer is one bit wider than the row index so it can say "full";
    // it is only used as an index while below N.
    assign wr_idx = IW'(wp_q);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        mem_d = mem_q;
        wp_d  = wp_q;
        ovf_d = ovf_q;

        if (clear_i) begin
            wp_d  = '0;
            ovf_d = 1'b0;
        end else if (cap_en_i && valid_i) begin
            if (wp_q < PW'(N)) begin
                // Two's-complement add wraps modulo 2^ACC_W, no saturation.
                mem_d[wr_idx] = accumulate_i ? (mem_q[wr_idx] + psum_i) : psum_i;
                wp_d          = wp_q + PW'(1);
            end else begin
                ovf_d = 1'b1;   // data and pointer stay as they are
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would create
    // order-dependent simulation races.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: storage is deliberately reset so a tile read after reset
            // (or a partially filled one) never exposes stale results; this
            // keeps mem in flops rather than a RAM macro, which is fine at N*N.
            mem_q <= '0;
            wp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            ovf_q <= ovf_d;
        end
    end

    assign wp_o      = wp_q;
    assign rd_data_o = mem_q[rd_idx_i];
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/acc_bank.sv
// -----------------------------------------------------------------------------
// acc_bank
// Receive-side buffer for one N x N result tile of the systolic array.
// Columns arrive skewed (column c lags column 0 by c cycles); each column is
// captured independently into its own acc_column, and row r is offered
// downstream once every column holds at least r+1 entries. Capture and drain
// run concurrently, so the array never has to stall.
// Ports:
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   start_i      : one-cycle pulse, begin a new tile (wins over acc_valid_i)
//   accumulate_i : (ACC_BANK_ACCUMULATE_EN only) sampled with start_i;
//                  1 = next tile adds into stored values
//   acc_valid_i  : per-column capture strobes
//   psum_i       : bottom-row partial sums, one per column
//   out_if       : row stream (row_o, row_idx_o, row_valid_o, row_ready_i)
//   done_o       : all N rows transferred; held until the next start_i
//   err_o        : sticky, a capture arrived for a full column
// Build option: define ACC_BANK_ACCUMULATE_EN to add accumulate_i and the
// accumulate-into-storage mode; otherwise captures always overwrite.
// -----------------------------------------------------------------------------
module acc_bank #(
    parameter  int N     = acc_bank_pkg::N,
    parameter  int ACC_W = acc_bank_pkg::ACC_W,
    localparam int LOG_N = acc_bank_pkg::idx_width(N),
    localparam int PW    = acc_bank_pkg::ptr_width(N)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
`ifdef ACC_BANK_ACCUMULATE_EN
    input  logic                    accumulate_i,
`endif
    input  logic [N-1:0]            acc_valid_i,
    input  logic [N-1:0][ACC_W-1:0] psum_i,
    acc_bank_if.master              out_if,
    output logic                    done_o,
    output logic                    err_o
);
    import acc_bank_pkg::*;

    acc_state_t              state_q, state_d;
    logic [LOG_N-1:0]        rr_q, rr_d;
    logic [PW-1:0]           wp [N];
    logic [N-1:0][ACC_W-1:0] row_data;
    logic [N-1:0]            ovf;
    logic                    row_valid;
    logic                    fire;
    logic                    cap_en;
    logic                    acc_mode;

`ifdef ACC_BANK_ACCUMULATE_EN
    logic acc_mode_q;

    // Mode is latched at start_i and applies to the whole tile that follows.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_mode_q <= 1'b0;
        end else if (start_i) begin
            acc_mode_q <= accumulate_i;
        end
    end

    assign acc_mode = acc_mode_q;
`else
    assign acc_mode = 1'b0;
`endif

    // start_i has priority: captures in the same cycle are dropped.
    assign cap_en = (state_q == S_ACC_ACTIVE) && !start_i;

    for (genvar c = 0; c < N; c++) begin : g_col
        acc_column #(
            .N     (N),
            .ACC_W (ACC_W)
        ) u_col (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .clear_i      (start_i),
            .cap_en_i     (cap_en),
            .valid_i      (acc_valid_i[c]),
            .psum_i       (psum_i[c]),
            .accumulate_i (acc_mode),
            .rd_idx_i     (rr_q),
            .wp_o         (wp[c]),
            .rd_data_o    (row_data[c]),
            .ovf_o        (ovf[c])
        );
    end

    // Row rr is complete once every column has written past it. Built only
    // from registered pointers, so a row appears the cycle after its last
    // column is captured and never depends on this cycle's strobes.
    always_comb begin
        row_valid = (state_q == S_ACC_ACTIVE);
        for (int c = 0; c < N; c++) begin
            if (wp[c] <= PW'(rr_q)) begin
                row_valid = 1'b0;
            end
        end
    end

    assign fire = row_valid && out_if.row_ready_i;

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        done_o  = (state_q == S_ACC_DONE);

        if (start_i) begin
            state_d = S_ACC_ACTIVE;
            rr_d    = '0;
        end else begin
            case (state_q)
                S_ACC_ACTIVE: begin
                    if (fire) begin
                        rr_d = rr_q + LOG_N'(1);
                        if (rr_q == LOG_N'(N - 1)) begin
                            state_d = S_ACC_DONE;
                        end
                    end
                end
                default: begin
                    // S_ACC_IDLE / S_ACC_DONE wait for start_i.
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_ACC_IDLE;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // rr_q only moves on a transfer, so row_o / row_idx_o hold under backpressure.
    assign out_if.row_o       = row_data;
    assign out_if.row_idx_o   = rr_q;
    assign out_if.row_valid_o = row_valid;
    assign err_o              = |ovf;

endmodule

// File: tb/tb_acc_bank.sv
// -----------------------------------------------------------------------------
// tb_acc_bank
// Directed testbench for acc_bank with N=4, ACC_W=32. Inputs change 1 time
// unit after the rising edge; outputs are observed at the same point, i.e.
// they reflect the state after the preceding edge.
// -----------------------------------------------------------------------------
module tb_acc_bank;
    import acc_bank_pkg::*;

    localparam int TN = 4;
    localparam int TW = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  start_i;
    logic [TN-1:0]         acc_valid_i;
    logic [TN-1:0][TW-1:0] psum_i;
    logic                  done_o;
    logic                  err_o;
`ifdef ACC_BANK_ACCUMULATE_EN
    logic                  accumulate_i;
`endif

    int checks = 0;
    int errors = 0;

    logic [TN-1:0][TW-1:0] got_rows [$];
    int                    got_idx  [$];
    int                    got_k    [$];
    int                    first_valid_k;

    acc_bank_if #(.N(TN), .ACC_W(TW)) out_if ();

    acc_bank #(.N(TN), .ACC_W(TW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
`ifdef ACC_BANK_ACCUMULATE_EN
        .accumulate_i (accumulate_i),
`endif
        .acc_valid_i  (acc_valid_i),
        .psum_i       (psum_i),
        .out_if       (out_if),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [TW-1:0] pat(input int r, input int c);
        return TW'(10 * r + c);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Skewed feed: at step k, column c carries row k-c if that row exists.
    task automatic set_skew(input int k, input bit use_pat, input logic [TW-1:0] cval);
        acc_valid_i = '0;
        psum_i      = '0;
        for (int c = 0; c < TN; c++) begin
            if ((k - c >= 0) && (k - c < TN)) begin
                acc_valid_i[c] = 1'b1;
                psum_i[c]      = use_pat ? pat(k - c, c) : cval;
            end
        end
    endtask

    task automatic do_start();
        start_i     = 1'b1;
        acc_valid_i = '0;
        tick();
        start_i     = 1'b0;
    endtask

    // Drives the skewed feed from step start_k and collects every row that is
    // handed over; ready is low until step 'stall'. Bounded to 60 cycles.
    task automatic run_tile(input int start_k, input int stall, input bit use_pat,
                            input logic [TW-1:0] cval);
        got_rows.delete();
        got_idx.delete();
        got_k.delete();
        first_valid_k = -1;
        for (int k = start_k; k < start_k + 60; k++) begin
            if (done_o) break;
            set_skew(k, use_pat, cval);
            out_if.row_ready_i = (k >= stall);
            if (out_if.row_valid_o && first_valid_k < 0) first_valid_k = k;
            if (out_if.row_valid_o && out_if.row_ready_i) begin
                got_rows.push_back(out_if.row_o);
                got_idx.push_back(int'(out_if.row_idx_o));
                got_k.push_back(k);
            end
            tick();
        end
        acc_valid_i        = '0;
        out_if.row_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        checks++;
        if (out_if.row_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_row_valid: got %b, expected 0", out_if.row_valid_o);
        end
        checks++;
        if (done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL rst_done_err: got done=%b err=%b, expected 0 0", done_o, err_o);
        end
        checks++;
        if (out_if.row_idx_o !== '0 || out_if.row_o !== '0) begin
            errors++; $display("FAIL rst_row: got idx=%0d row=%h, expected 0 0", out_if.row_idx_o, out_if.row_o);
        end
        rst_ni = 1'b1;
        tick();
        checks++;
        if (out_if.row_valid_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL idle_after_rst: got valid=%b done=%b, expected 0 0", out_if.row_valid_o, done_o);
        end
    endtask

    task automatic test_skewed_fill();
        do_start();
        run_tile(0, 0, 1'b1, '0);
        // Column 3 first captures at step 3, so row 0 is visible at step 4.
        checks++;
        if (first_valid_k != 4) begin
            errors++; $display("FAIL fill_first_valid: got step %0d, expected 4", first_valid_k);
        end
        checks++;
        if (got_rows.size() != TN) begin
            errors++; $display("FAIL fill_rows: got %0d rows, expected %0d", got_rows.size(), TN);
        end
        for (int r = 0; r < got_rows.size() && r < TN; r++) begin
            checks++;
            if (got_idx[r] != r) begin
                errors++; $display("FAIL fill_idx%0d: got %0d, expected %0d", r, got_idx[r], r);
            end
            for (int c = 0; c < TN; c++) begin
                checks++;
                if (got_rows[r][c] !== pat(r, c)) begin
                    errors++; $display("FAIL fill_r%0d_c%0d: got %0d, expected %0d", r, c, got_rows[r][c], pat(r, c));
                end
            end
        end
        tick();
        tick();
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || out_if.row_valid_o !== 1'b0) begin
            errors++; $display("FAIL fill_end: got done=%b err=%b valid=%b, expected 1 0 0", done_o, err_o, out_if.row_valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [TN-1:0][TW-1:0] exp_row;
        for (int c = 0; c < TN; c++) exp_row[c] = pat(0, c);
        do_start();
        for (int k = 0; k < 20; k++) begin
            set_skew(k, 1'b1, '0);
            out_if.row_ready_i = 1'b0;
            tick();
            if (k >= 3) begin
                checks++;
                if (out_if.row_valid_o !== 1'b1 || out_if.row_idx_o !== '0 || out_if.row_o !== exp_row) begin
                    errors++; $display("FAIL bp_hold_k%0d: got valid=%b idx=%0d row=%h, expected 1 0 %h",
                                       k, out_if.row_valid_o, out_if.row_idx_o, out_if.row_o, exp_row);
                end
            end
        end
        acc_valid_i = '0;
        run_tile(20, 0, 1'b1, '0);
        checks++;
        if (got_rows.size() != TN) begin
            errors++; $display("FAIL bp_rows: got %0d rows, expected %0d", got_rows.size(), TN);
        end
        for (int r = 0; r < got_rows.size() && r < TN; r++) begin
            checks++;
            if (got_k[r] != 20 + r || got_idx[r] != r) begin
                errors++; $display("FAIL bp_rate%0d: got step %0d idx %0d, expected step %0d idx %0d", r, got_k[r], got_idx[r], 20 + r, r);
            end
            for (int c = 0; c < TN; c++) begin
                checks++;
                if (got_rows[r][c] !== pat(r, c)) begin
                    errors++; $display("FAIL bp_r%0d_c%0d: got %0d, expected %0d", r, c, got_rows[r][c], pat(r, c));
                end
            end
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++; $display("FAIL bp_done: got %b, expected 1", done_o);
        end
    endtask

    task automatic test_overflow();
        do_start();
        for (int k = 0; k < 7; k++) begin
            set_skew(k, 1'b1, '0);
            out_if.row_ready_i = 1'b0;
            tick();
        end
        acc_valid_i = 4'b0100;
        psum_i      = '0;
        psum_i[2]   = 32'd999;
        tick();
        acc_valid_i = '0;
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got %b, expected 1", err_o);
        end
        tick();
        tick();
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %b, expected 1", err_o);
        end
        run_tile(7, 0, 1'b1, '0);
        checks++;
        if (got_rows.size() != TN) begin
            errors++; $display("FAIL ovf_rows: got %0d rows, expected %0d", got_rows.size(), TN);
        end
        for (int r = 0; r < got_rows.size() && r < TN; r++) begin
            for (int c = 0; c < TN; c++) begin
                checks++;
                if (got_rows[r][c] !== pat(r, c)) begin
                    errors++; $display("FAIL ovf_r%0d_c%0d: got %0d, expected %0d", r, c, got_rows[r][c], pat(r, c));
                end
            end
        end
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b1) begin
            errors++; $display("FAIL ovf_end: got done=%b err=%b, expected 1 1", done_o, err_o);
        end
        do_start();
        checks++;
        if (err_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got err=%b done=%b, expected 0 0", err_o, done_o);
        end
    endtask

    task automatic test_restart();
        do_start();
        for (int i = 0; i < 2; i++) begin
            acc_valid_i = '1;
            for (int c = 0; c < TN; c++) psum_i[c] = TW'(100 * (i + 1) + c);
            out_if.row_ready_i = 1'b0;
            tick();
        end
        checks++;
        if (out_if.row_valid_o !== 1'b1) begin
            errors++; $display("FAIL rs_partial_valid: got %b, expected 1", out_if.row_valid_o);
        end
        start_i     = 1'b1;
        acc_valid_i = '1;
        for (int c = 0; c < TN; c++) psum_i[c] = 32'd555;
        tick();
        start_i     = 1'b0;
        acc_valid_i = '0;
        checks++;
        if (out_if.row_valid_o !== 1'b0 || out_if.row_idx_o !== '0) begin
            errors++; $display("FAIL rs_cleared: got valid=%b idx=%0d, expected 0 0", out_if.row_valid_o, out_if.row_idx_o);
        end
        run_tile(0, 0, 1'b1, '0);
        checks++;
        if (got_rows.size() != TN || done_o !== 1'b1) begin
            errors++; $display("FAIL rs_rows: got %0d rows done=%b, expected %0d 1", got_rows.size(), done_o, TN);
        end
        for (int r = 0; r < got_rows.size() && r < TN; r++) begin
            for (int c = 0; c < TN; c++) begin
                checks++;
                if (got_rows[r][c] !== pat(r, c)) begin
                    errors++; $display("FAIL rs_r%0d_c%0d: got %0d, expected %0d", r, c, got_rows[r][c], pat(r, c));
                end
            end
        end
    endtask

    task automatic test_reset_mid_tile();
        do_start();
        for (int k = 0; k < 7; k++) begin
            set_skew(k, 1'b1, '0);
            out_if.row_ready_i = 1'b0;
            tick();
        end
        acc_valid_i = 4'b0001;
        psum_i      = '0;
        psum_i[0]   = 32'd77;
        tick();
        acc_valid_i = '0;
        checks++;
        if (out_if.row_valid_o !== 1'b1 || err_o !== 1'b1) begin
            errors++; $display("FAIL rm_pre: got valid=%b err=%b, expected 1 1", out_if.row_valid_o, err_o);
        end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        checks++;
        if (out_if.row_valid_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL rm_flags: got valid=%b done=%b err=%b, expected 0 0 0", out_if.row_valid_o, done_o, err_o);
        end
        checks++;
        if (out_if.row_idx_o !== '0 || out_if.row_o !== '0) begin
            errors++; $display("FAIL rm_data: got idx=%0d row=%h, expected 0 0", out_if.row_idx_o, out_if.row_o);
        end
        // Idle must ignore captures until start_i.
        for (int k = 0; k < 7; k++) begin
            set_skew(k, 1'b1, '0);
            out_if.row_ready_i = 1'b1;
            tick();
        end
        acc_valid_i        = '0;
        out_if.row_ready_i = 1'b0;
        checks++;
        if (out_if.row_valid_o !== 1'b0 || done_o !== 1'b0 || out_if.row_o !== '0) begin
            errors++; $display("FAIL rm_idle: got valid=%b done=%b row=%h, expected 0 0 0", out_if.row_valid_o, done_o, out_if.row_o);
        end
    endtask

`ifdef ACC_BANK_ACCUMULATE_EN
    task automatic test_accumulate();
        logic [TW-1:0] exp_v;
        for (int pass = 0; pass < 2; pass++) begin
            accumulate_i = 1'b0;
            do_start();
            run_tile(0, 0, 1'b0, (pass == 0) ? 32'd5 : 32'h7FFF_FFFF);
            checks++;
            if (got_rows.size() != TN || got_rows[0][1] !== ((pass == 0) ? 32'd5 : 32'h7FFF_FFFF)) begin
                errors++; $display("FAIL acc_base%0d: got %0d rows, expected %0d with base value", pass, got_rows.size(), TN);
            end
            accumulate_i = 1'b1;
            do_start();
            accumulate_i = 1'b0;
            run_tile(0, 0, 1'b0, (pass == 0) ? psum_t'(-7) : 32'd1);
            exp_v = (pass == 0) ? psum_t'(-2) : 32'h8000_0000;
            checks++;
            if (got_rows.size() != TN || done_o !== 1'b1) begin
                errors++; $display("FAIL acc_rows%0d: got %0d rows done=%b, expected %0d 1", pass, got_rows.size(), done_o, TN);
            end
            for (int r = 0; r < got_rows.size() && r < TN; r++) begin
                for (int c = 0; c < TN; c++) begin
                    checks++;
                    if (got_rows[r][c] !== exp_v) begin
                        errors++; $display("FAIL acc%0d_r%0d_c%0d: got %h, expected %h", pass, r, c, got_rows[r][c], exp_v);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        rst_ni             = 1'b0;
        start_i            = 1'b0;
        acc_valid_i        = '0;
        psum_i             = '0;
        out_if.row_ready_i = 1'b0;
`ifdef ACC_BANK_ACCUMULATE_EN
        accumulate_i       = 1'b0;
`endif
        test_reset();
        test_skewed_fill();
        test_backpressure();
        test_overflow();
        test_restart();
        test_reset_mid_tile();
`ifdef ACC_BANK_ACCUMULATE_EN
        test_accumulate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
